// File: rtl/pc_sequencer.sv
// Program counter with a return-address stack for the fetch stage.
// A stack fault latches an error flag and parks the sequencer in HALT until reset.
module pc_sequencer #(
  parameter int PC_WIDTH    = 5,
  parameter int STACK_DEPTH = 8,
  parameter int SP_WIDTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                jmp,
  input  logic                cal,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [SP_WIDTH-1:0] stack_level,
  output logic                overflow_err,
  output logic                underflow_err,
  output logic                halted
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_WIDTH-1:0] FULL_LEVEL = SP_WIDTH'(STACK_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [SP_WIDTH-1:0] r_level;
  logic                r_ovf;
  logic                r_unf;
  logic                r_halted;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic                w_active;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [SP_WIDTH-1:0] w_level_m1;
  logic [IDX_W-1:0]    w_push_idx;
  logic [IDX_W-1:0]    w_pop_idx;
  logic [PC_WIDTH-1:0] w_pop_addr;

  // Decode of the current cycle's action; ret outranks cal, so a push needs !ret.
  always_comb begin
    w_active   = 1'b0;
    w_empty    = 1'b0;
    w_full     = 1'b0;
    w_push     = 1'b0;
    w_active   = en && (r_state == ST_RUN);
    w_empty    = (r_level == {SP_WIDTH{1'b0}});
    w_full     = (r_level == FULL_LEVEL);
    w_push     = w_active && !ret && cal && !w_full;
    w_pc_inc   = r_pc + PC_WIDTH'(1);
    w_level_m1 = r_level - SP_WIDTH'(1);
    w_push_idx = r_level[IDX_W-1:0];
    w_pop_idx  = w_level_m1[IDX_W-1:0];
    w_pop_addr = r_stack[w_pop_idx];
  end

  // Return-address storage; contents are intentionally left uninitialised.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  // Sequencer state machine, PC and fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= {PC_WIDTH{1'b0}};
      r_level  <= {SP_WIDTH{1'b0}};
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_active) begin
      if (ret) begin
        if (!w_empty) begin
          r_pc    <= w_pop_addr;
          r_level <= w_level_m1;
        end else begin
          r_unf    <= 1'b1;
          r_halted <= 1'b1;
          r_state  <= ST_HALT;
        end
      end else if (cal) begin
        if (!w_full) begin
          r_pc    <= jmp_addr;
          r_level <= r_level + SP_WIDTH'(1);
        end else begin
          r_ovf    <= 1'b1;
          r_halted <= 1'b1;
          r_state  <= ST_HALT;
        end
      end else if (jmp) begin
        r_pc <= jmp_addr;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign pc            = r_pc;
  assign stack_level   = r_level;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
  assign halted        = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized strobes.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       jmp = 1'b0;
  logic       cal = 1'b0;
  logic       ret = 1'b0;
  logic [4:0] jmp_addr = 5'd0;
  logic [4:0] pc;
  logic [3:0] stack_level;
  logic       overflow_err;
  logic       underflow_err;
  logic       halted;

  int checks = 0;
  int errors = 0;

  int m_pc = 0;
  int m_stack[$];
  int m_ovf = 0;
  int m_unf = 0;
  int m_halt = 0;
  bit m_valid = 1'b0;

  pc_sequencer #(.PC_WIDTH(5), .STACK_DEPTH(8), .SP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .cal(cal), .ret(ret),
    .jmp_addr(jmp_addr), .pc(pc), .stack_level(stack_level),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, from the architectural rules.
  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
    end else if (en && !m_halt) begin
      if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_unf = 1; m_halt = 1; end
      end else if (cal) begin
        if (m_stack.size() < 8) begin
          m_stack.push_back((m_pc + 1) % 32);
          m_pc = int'(jmp_addr);
        end else begin m_ovf = 1; m_halt = 1; end
      end else if (jmp) begin
        m_pc = int'(jmp_addr);
      end else begin
        m_pc = (m_pc + 1) % 32;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit j, input bit c, input bit rt, input int a);
    rst = r; en = e; jmp = j; cal = c; ret = rt; jmp_addr = 5'(a);
    @(posedge clk);
    model_edge();
    m_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic expect_lit(input string tag, input int e_pc, input int e_lvl,
                            input int e_ovf, input int e_unf, input int e_halt);
    check({tag, ".pc"}, int'(pc), e_pc);
    check({tag, ".level"}, int'(stack_level), e_lvl);
    check({tag, ".ovf"}, int'(overflow_err), e_ovf);
    check({tag, ".unf"}, int'(underflow_err), e_unf);
    check({tag, ".halted"}, int'(halted), e_halt);
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc.pc", int'(pc), m_pc);
      check("cyc.level", int'(stack_level), m_stack.size());
      check("cyc.ovf", int'(overflow_err), m_ovf);
      check("cyc.unf", int'(underflow_err), m_unf);
      check("cyc.halted", int'(halted), m_halt);
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    expect_lit("reset", 0, 0, 0, 0, 0);

    // Free-running sequential fetch wraps at 31.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      check("seq.pc", int'(pc), (i + 1) % 32);
    end
    check("seq.level", int'(stack_level), 0);

    // Plain jump.
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17);
    expect_lit("jmp", 17, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("jmp.next", int'(pc), 18);

    // Call then return resumes after the call.
    do_reset();
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20);
    expect_lit("call", 20, 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("call.next", int'(pc), 21);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    expect_lit("ret", 5, 0, 0, 0, 0);

    // Fill the stack, overflow, frozen HALT, then reset.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10 + i);
    expect_lit("full", 17, 8, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    expect_lit("ovf", 17, 8, 1, 0, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    expect_lit("ovf.frozen", 17, 8, 1, 0, 1);
    do_reset();
    expect_lit("ovf.rst", 0, 0, 0, 0, 0);

    // Underflow on empty stack.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    expect_lit("unf", 0, 0, 0, 1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_lit("unf.frozen", 0, 0, 0, 1, 1);

    // Stall swallows a call.
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 25);
    expect_lit("stall", 2, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    expect_lit("stall.after", 3, 0, 0, 0, 0);

    // Simultaneous ret+cal: pop only.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20);
    expect_lit("two", 20, 2, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5);
    expect_lit("retcal", 11, 1, 0, 0, 0);

    // Randomized strobes; occasional reset recovers from HALT.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0, int'($urandom_range(0, 31)));
    end

    m_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and return-address stack for the core.
- Consumes the decoder's control-flow strobes (jmp, cal, ret) and jump target, and produces the fetch address for instruction memory each cycle.
- Owns call-stack depth tracking, overflow/underflow detection and a halt state on stack fault.
- Sits between the decoder outputs and the instruction-memory address input.

Parameters:
- PC_WIDTH, 5, width of program counter / instruction address.
- STACK_DEPTH, 8, number of return-address entries (power of two not required, >=1).
- SP_WIDTH, 4, stack-pointer width; must satisfy 2**SP_WIDTH > STACK_DEPTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = hold all state (pipeline stall).
- jmp  in  1  decoder jump strobe (also asserted by decoder together with cal).
- cal  in  1  decoder call strobe.
- ret  in  1  decoder return strobe.
- jmp_addr  in  PC_WIDTH  jump/call target.
- pc  out  PC_WIDTH  current fetch address (registered).
- stack_level  out  SP_WIDTH  number of valid return entries.
- overflow_err  out  1  sticky: call attempted with full stack.
- underflow_err  out  1  sticky: return attempted with empty stack.
- halted  out  1  1 while in HALT state.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous paths.
- Reset values: pc=0, stack_level=0, overflow_err=0, underflow_err=0, halted=0, state=RUN. Stack RAM contents are not cleared (don't-care).
- States:
  - RUN: normal sequencing.
  - HALT: entered on any stack fault; exits only via rst.
- RUN with en=1, evaluated in priority order ret > cal > jmp > sequential:
  - ret, stack_level>0: pc <= stack[stack_level-1]; stack_level--.
  - ret, stack_level==0: underflow_err<=1, go HALT; pc and stack_level unchanged.
  - cal (jmp value ignored), stack_level<STACK_DEPTH: stack[stack_level] <= pc+1 (mod 2**PC_WIDTH); stack_level++; pc <= jmp_addr.
  - cal, stack_level==STACK_DEPTH: overflow_err<=1, go HALT; pc, stack_level and stack contents unchanged.
  - jmp only: pc <= jmp_addr; stack untouched.
  - none: pc <= pc+1, wraps 2**PC_WIDTH-1 -> 0.
- en=0 in RUN: all registers hold; strobes ignored, not queued.
- HALT: pc, stack_level and error flags frozen regardless of en and strobes; halted=1.
- Simultaneous ret+cal (not produced by decoder): ret wins, cal ignored that cycle.
- Latency: a strobe sampled at edge N takes effect in pc after edge N (one-cycle registered update). Errors and halted assert after the same edge.
- Return address pushed is pc+1 of the calling instruction, so execution resumes after the call.
- rst asserted mid-call or in HALT: next edge restores all reset values; rst overrides en.

Test Plan:
- Reset, en=1, no strobes for 40 cycles -> pc 0,1,...,31,0,...,7 (wraps at 31); stack_level stays 0.
- pc=3, jmp=1, jmp_addr=17 -> next pc=17, stack_level=0; following cycle pc=18.
- pc=4, cal=1+jmp=1, jmp_addr=20 -> pc=20, stack_level=1; two cycles later ret=1 at pc=21 -> pc=5, stack_level=0.
- 8 nested calls fill the stack (stack_level=8); a 9th cal -> overflow_err=1, halted=1, pc unchanged. Further jmp/ret have no effect until rst; after rst all outputs are 0.
- ret at stack_level=0 -> underflow_err=1, halted=1, pc unchanged; en=0 on a cycle with cal=1 -> pc and stack_level held, and the call is not executed later.
- ret=1 and cal=1 together with stack_level=2 -> pops (stack_level=1, pc=popped address), no push.
